board_io_conditioner: RTL
=========================

Name: board_io_conditioner

Overview:
Parametrised board-I/O front end between raw FPGA pins (slide switches, push buttons) and the pipelined RISC-V core's I/O ports. Per channel it does synchronisation, debounce, and press-edge detection, plus sticky press-event capture. It also derives a stretched, glitch-free active-low core reset from a debounced run switch. Replaces direct wiring of raw pins into i_io_sw/i_io_btn/i_rst_n.

Parameters:
N_SW, 18, number of slide-switch channels (>=1)
N_BTN, 4, number of push-button channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (>=1; 10 ms at 50 MHz)
BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (inverted at input)
RUN_SW_IDX, 17, index of the debounced switch acting as core run/reset_n (< N_SW)
RST_HOLD_CYCLES, 16, cycles o_core_rst_n stays low after run switch goes high (>=1)

Ports:
i_clk  input  1  system clock (CLOCK_50 domain)
i_rst  input  1  synchronous, active-high reset
i_sw  input  N_SW  raw asynchronous switch pins
i_btn  input  N_BTN  raw asynchronous button pins
i_evt_clr  input  N_BTN  per-channel clear of sticky press event (write-1-to-clear, level)
o_sw  output  N_SW  debounced switch levels
o_btn  output  N_BTN  debounced button levels, 1 = pressed
o_btn_press  output  N_BTN  one-cycle pulse on debounced press (0->1)
o_btn_evt  output  N_BTN  sticky press flag
o_core_rst_n  output  1  stretched active-low reset for the core
o_core_run  output  1  1 when reset FSM is in RUN

Behaviour:
- Reset: one clock, synchronous, active-high. While i_rst=1 at an edge: all sync flops, debounced levels, counters, o_btn_press, o_btn_evt = 0. Button sync flops load the inactive (not-pressed) level. FSM -> RST_ASSERT. o_core_rst_n=0, o_core_run=0. Reset mid-debounce discards the count.
- Input stage: buttons XOR'd with BTN_ACTIVE_LOW before the sync chain; switches passed through. SYNC_STAGES-flop chain per channel; no combinational path from raw pin to any output.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync output == debounced level: counter cleared to 0.
  - Mismatch: counter increments.
  - Mismatch with counter == DEBOUNCE_CYCLES-1: debounced level flips and counter clears.
  - A single-cycle return to the old level restarts the count.
  - Latency: raw level stable from edge 0 -> debounced output changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Counter never wraps.
- Press edge: o_btn_press[i] = registered (o_btn[i] & ~o_btn_prev[i]). High exactly one cycle, in the cycle o_btn[i] first reads 1. Release produces no press pulse.
- Sticky: o_btn_evt[i] set by press pulse, cleared by i_evt_clr[i]. Same-cycle set and clear -> set wins (event not lost). Clear while already 0 -> no effect.
- Reset FSM (states RST_ASSERT, RST_HOLD, RUN):
  - RST_ASSERT: o_core_rst_n=0. Go to RST_HOLD when o_sw[RUN_SW_IDX]=1; the hold counter loads 0.
  - RST_HOLD: o_core_rst_n=0, counter increments. Go to RUN on the edge where the counter reaches RST_HOLD_CYCLES-1. If o_sw[RUN_SW_IDX] drops to 0 -> RST_ASSERT.
  - RUN: o_core_rst_n=1, o_core_run=1. o_sw[RUN_SW_IDX]=0 -> RST_ASSERT next edge.
  - o_core_rst_n and o_core_run are registered FSM decodes.
  - First RUN cycle: RST_HOLD_CYCLES cycles after the RST_HOLD entry edge.
- Switch channels have no edge/sticky logic.

Optional Feature:
BOARD_IO_RELEASE_EVT_EN
- Defined: adds output o_btn_release[N_BTN]. It is a one-cycle pulse on a debounced 1->0 transition, with the same timing rules as o_btn_press, and reset value 0.
- Undefined: port and logic absent. Press-only behaviour as above.

Test Plan:
(All with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, BTN_ACTIVE_LOW=1, N_BTN=4.)
- Reset: i_rst=1 for 2 cycles with i_btn=4'hF, i_sw all 1 -> all outputs 0, o_core_rst_n=0. After release, o_sw all 1 at edge 6; o_btn stays 0.
- Clean press: i_btn[0] 1->0 held -> o_btn[0]=1 at edge 6; o_btn_press[0]=1 for that cycle only; o_btn_evt[0]=1 and stays 1.
- Bounce: i_btn[1] toggles 0,1,0,1 on alternate cycles, then held 0 -> no change until 6 cycles after last toggle; exactly one press pulse.
- Sticky race: i_evt_clr[2]=1 in the same cycle as o_btn_press[2] -> o_btn_evt[2]=1. Clear one cycle later -> 0.
- Run sequence: SW[17] 0->1 held -> RST_HOLD entered at edge 6, o_core_rst_n=1 from edge 9. SW[17]=0 during RST_HOLD -> stays 0, FSM back to RST_ASSERT.
- With BOARD_IO_RELEASE_EVT_EN: press then release of i_btn[3] -> one o_btn_press[3] and one o_btn_release[3] pulse, each 1 cycle; o_btn_evt[3] unaffected by release.

Source files
------------

// File: rtl/board_io_if.sv
// Board I/O bundle between raw FPGA pins and the conditioned core-facing signals.
//   master : board/test side, drives raw pins and event clears, observes results
//   slave  : board_io_conditioner side
// Optional macro BOARD_IO_RELEASE_EVT_EN adds o_btn_release.
interface board_io_if #(
  parameter int N_SW  = 18,
  parameter int N_BTN = 4
);
  logic [N_SW-1:0]  i_sw;
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] i_evt_clr;
  logic [N_SW-1:0]  o_sw;
  logic [N_BTN-1:0] o_btn;
  logic [N_BTN-1:0] o_btn_press;
  logic [N_BTN-1:0] o_btn_evt;
  logic             o_core_rst_n;
  logic             o_core_run;
`ifdef BOARD_IO_RELEASE_EVT_EN
  logic [N_BTN-1:0] o_btn_release;
`endif

  modport master (
`ifdef BOARD_IO_RELEASE_EVT_EN
    input  o_btn_release,
`endif
    output i_sw, i_btn, i_evt_clr,
    input  o_sw, o_btn, o_btn_press, o_btn_evt, o_core_rst_n, o_core_run
  );

  modport slave (
`ifdef BOARD_IO_RELEASE_EVT_EN
    output o_btn_release,
`endif
    input  i_sw, i_btn, i_evt_clr,
    output o_sw, o_btn, o_btn_press, o_btn_evt, o_core_rst_n, o_core_run
  );
endinterface

// File: rtl/board_io_conditioner.sv
// Board I/O front end: synchronises and debounces slide switches and push
// buttons, produces press pulses and sticky press flags, and derives a
// stretched active-low core reset from a debounced run switch.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   io     : board_io_if.slave (raw i_sw/i_btn/i_evt_clr in; o_sw, o_btn,
//            o_btn_press, o_btn_evt, o_core_rst_n, o_core_run out)
// Optional macro BOARD_IO_RELEASE_EVT_EN: adds o_btn_release pulse on 1->0.
module board_io_conditioner #(
  parameter int N_SW            = 18,
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int RUN_SW_IDX      = 17,
  parameter int RST_HOLD_CYCLES = 16
) (
  input logic       i_clk,
  input logic       i_rst,
  board_io_if.slave io
);

  localparam int N_CH = N_SW + N_BTN;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW   = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {RST_ASSERT, RST_HOLD, RUN} state_t;

  // Buttons are normalised to 1 = pressed before synchronisation, so the
  // all-zero reset value of the chain is the not-pressed level.
  logic [N_BTN-1:0] btn_in;
  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~io.i_btn : io.i_btn;

  // Switches occupy [N_SW-1:0], buttons [N_CH-1:N_SW] of every channel vector.
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] synced;
  logic [N_CH-1:0] deb;
  logic [N_CH-1:0] deb_next;
  logic [N_CH-1:0] flip;
  logic [CW-1:0]   cnt [N_CH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= {btn_in, io.i_sw};
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      flip[i] = (synced[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end

  assign deb_next = deb ^ flip;

  // Counter tops out at DEBOUNCE_CYCLES-1, where a mismatch flips the level
  // and clears it, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      deb <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      deb <= deb_next;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if ((synced[i] == deb[i]) || flip[i]) cnt[i] <= '0;
        else                                  cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  logic [N_BTN-1:0] btn_deb;
  logic [N_BTN-1:0] btn_next;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] evt;
  assign btn_deb  = deb[N_CH-1:N_SW];
  assign btn_next = deb_next[N_CH-1:N_SW];

  // Edge terms use the level being registered this cycle, so the pulse is
  // high in the same cycle the debounced level first shows the new value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      press <= '0;
      evt   <= '0;
    end else begin
      press <= btn_next & ~btn_deb;
      evt   <= press | (evt & ~io.i_evt_clr);
    end
  end

`ifdef BOARD_IO_RELEASE_EVT_EN
  logic [N_BTN-1:0] release_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) release_q <= '0;
    else       release_q <= btn_deb & ~btn_next;
  end
  assign io.o_btn_release = release_q;
`endif

  // The FSM follows the run-switch level as it is being registered, so its
  // transitions land on the same edge that o_sw[RUN_SW_IDX] changes.
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          core_rst_n;
  logic          core_run;
  logic          run_sw;
  assign run_sw = deb_next[RUN_SW_IDX];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= RST_ASSERT;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      core_run   <= 1'b0;
    end else begin
      case (state)
        RST_ASSERT: begin
          if (run_sw) begin
            state    <= RST_HOLD;
            hold_cnt <= '0;
          end
        end
        RST_HOLD: begin
          if (!run_sw) begin
            state <= RST_ASSERT;
          end else if (hold_cnt == HW'(RST_HOLD_CYCLES - 1)) begin
            state      <= RUN;
            core_rst_n <= 1'b1;
            core_run   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!run_sw) begin
            state      <= RST_ASSERT;
            core_rst_n <= 1'b0;
            core_run   <= 1'b0;
          end
        end
        default: begin
          state      <= RST_ASSERT;
          core_rst_n <= 1'b0;
          core_run   <= 1'b0;
        end
      endcase
    end
  end

  assign io.o_sw         = deb[N_SW-1:0];
  assign io.o_btn        = btn_deb;
  assign io.o_btn_press  = press;
  assign io.o_btn_evt    = evt;
  assign io.o_core_rst_n = core_rst_n;
  assign io.o_core_run   = core_run;

endmodule
